// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the load/store
// unit (requester 0) and the DMA/debug port (requester 1). One access is
// granted per cycle; byte/half/word requests become a word address, byte
// mask and lane-replicated store data. Responses come back one cycle later,
// aligned and extended, to whichever requester issued the access.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration. Without
// it, requester 0 has fixed priority and a starvation counter bounds how
// long requester 1 can wait.
module dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_r0_valid,
    input  logic              i_r1_valid,
    output logic              o_r0_ready,
    output logic              o_r1_ready,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic              i_r0_we,
    input  logic              i_r1_we,
    input  logic [1:0]        i_r0_size,
    input  logic [1:0]        i_r1_size,
    input  logic              i_r0_uns,
    input  logic              i_r1_uns,
    input  logic [31:0]       i_r0_wdata,
    input  logic [31:0]       i_r1_wdata,
    output logic              o_r0_rsp_valid,
    output logic              o_r1_rsp_valid,
    output logic [31:0]       o_r0_rsp_rdata,
    output logic [31:0]       o_r1_rsp_rdata,
    output logic              o_r0_rsp_err,
    output logic              o_r1_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    // Valids are masked by reset so nothing is granted (and memory is never
    // written) while reset is asserted.
    logic req_v0, req_v1;
    logic gnt0, gnt1, any_gnt;

    assign req_v0  = i_r0_valid & i_rst_n;
    assign req_v1  = i_r1_valid & i_rst_n;
    assign any_gnt = gnt0 | gnt1;

`ifdef DMEM_ARB_RR_EN
    // Requester favoured on the next contended cycle (0 out of reset).
    logic rr_pri;

    // Round-robin grant: the favoured requester wins a tie.
    always_comb begin
        gnt1 = req_v1 & (~req_v0 | rr_pri);
        gnt0 = req_v0 & ~gnt1;
    end

    // After a grant, the other requester becomes favoured.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rr_pri <= 1'b0;
        else if (any_gnt)
            rr_pri <= gnt0;
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // Number of consecutive cycles requester 1 has been passed over.
    logic [7:0] starve_cnt;

    // Fixed priority to requester 0 unless requester 1 has waited too long.
    always_comb begin
        gnt1 = req_v1 & (~req_v0 | (starve_cnt == STARVE_LIM));
        gnt0 = req_v0 & ~gnt1;
    end

    // Count requester-1 losses; saturate at the limit, clear once it is
    // served or stops asking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            starve_cnt <= '0;
        else if (!req_v1 || gnt1)
            starve_cnt <= '0;
        else if (gnt0 && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 8'd1;
    end
`endif

    assign o_r0_ready = gnt0;
    assign o_r1_ready = gnt1;

    // Winner's request fields.
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_off;

    // Mux the granted requester's fields.
    always_comb begin
        sel_addr  = gnt1 ? i_r1_addr  : i_r0_addr;
        sel_we    = gnt1 ? i_r1_we    : i_r0_we;
        sel_size  = gnt1 ? i_r1_size  : i_r0_size;
        sel_uns   = gnt1 ? i_r1_uns   : i_r0_uns;
        sel_wdata = gnt1 ? i_r1_wdata : i_r0_wdata;
    end

    assign sel_off = sel_addr[1:0];

    logic        dec_err;
    logic [3:0]  dec_mask;
    logic [31:0] dec_wdata;

    // Size/offset decode: lane mask, replicated store data, alignment error.
    always_comb begin
        dec_err   = 1'b0;
        dec_mask  = 4'b0000;
        dec_wdata = '0;
        case (sel_size)
            2'b00: begin
                dec_mask  = 4'b0001 << sel_off;
                dec_wdata = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                dec_err   = sel_off[0];
                dec_mask  = 4'b0011 << sel_off;
                dec_wdata = {2{sel_wdata[15:0]}};
            end
            2'b10: begin
                dec_err   = |sel_off;
                dec_mask  = 4'b1111;
                dec_wdata = sel_wdata;
            end
            default: dec_err = 1'b1;
        endcase
    end

    // Memory port: idle cycles and errored requests never touch memory.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_bmask = 4'b0000;
        o_mem_wren  = 1'b0;
        o_mem_wdata = '0;
        if (any_gnt) begin
            o_mem_addr = {sel_addr[ADDR_W-1:2], 2'b00};
            if (!dec_err) begin
                o_mem_bmask = dec_mask;
                o_mem_wren  = sel_we;
            end
            if (sel_we)
                o_mem_wdata = dec_wdata;
        end
    end

    // Response tracking for the access currently in the memory's read stage.
    logic       trk_vld;
    logic       trk_id;
    logic       trk_we;
    logic [1:0] trk_off;
    logic [1:0] trk_size;
    logic       trk_uns;
    logic       trk_err;

    // Capture every accepted request; reset drops anything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trk_vld  <= 1'b0;
            trk_id   <= 1'b0;
            trk_we   <= 1'b0;
            trk_off  <= 2'b00;
            trk_size <= 2'b00;
            trk_uns  <= 1'b0;
            trk_err  <= 1'b0;
        end else begin
            trk_vld  <= any_gnt;
            trk_id   <= gnt1;
            trk_we   <= sel_we;
            trk_off  <= sel_off;
            trk_size <= sel_size;
            trk_uns  <= sel_uns;
            trk_err  <= dec_err;
        end
    end

    logic [31:0] lane;
    logic [31:0] fmt;

    // Shift the addressed lane down and extend it; stores/errors read as 0.
    always_comb begin
        lane = i_mem_rdata >> {trk_off, 3'b000};
        case (trk_size)
            2'b00:   fmt = trk_uns ? {24'b0, lane[7:0]}
                                   : {{24{lane[7]}}, lane[7:0]};
            2'b01:   fmt = trk_uns ? {16'b0, lane[15:0]}
                                   : {{16{lane[15]}}, lane[15:0]};
            default: fmt = lane;
        endcase
        if (!trk_vld || trk_we || trk_err)
            fmt = '0;
    end

    // Route the response to its owner only.
    always_comb begin
        o_r0_rsp_valid = trk_vld & ~trk_id;
        o_r1_rsp_valid = trk_vld &  trk_id;
        o_r0_rsp_err   = o_r0_rsp_valid & trk_err;
        o_r1_rsp_err   = o_r1_rsp_valid & trk_err;
        o_r0_rsp_rdata = o_r0_rsp_valid ? fmt : '0;
        o_r1_rsp_rdata = o_r1_rsp_valid ? fmt : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with directed scenarios. A byte-array
// reference memory plus plain arbitration rules predict grants, memory port
// values and responses; a separate word memory plays the real data RAM.
module tb_dmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int SMAX   = 3;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_r0_valid = 1'b0, i_r1_valid = 1'b0;
    logic        o_r0_ready, o_r1_ready;
    logic [15:0] i_r0_addr = '0, i_r1_addr = '0;
    logic        i_r0_we = 1'b0, i_r1_we = 1'b0;
    logic [1:0]  i_r0_size = '0, i_r1_size = '0;
    logic        i_r0_uns = 1'b0, i_r1_uns = 1'b0;
    logic [31:0] i_r0_wdata = '0, i_r1_wdata = '0;
    logic        o_r0_rsp_valid, o_r1_rsp_valid;
    logic [31:0] o_r0_rsp_rdata, o_r1_rsp_rdata;
    logic        o_r0_rsp_err, o_r1_rsp_err;
    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(SMAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_r0_valid(i_r0_valid), .i_r1_valid(i_r1_valid),
        .o_r0_ready(o_r0_ready), .o_r1_ready(o_r1_ready),
        .i_r0_addr(i_r0_addr), .i_r1_addr(i_r1_addr),
        .i_r0_we(i_r0_we), .i_r1_we(i_r1_we),
        .i_r0_size(i_r0_size), .i_r1_size(i_r1_size),
        .i_r0_uns(i_r0_uns), .i_r1_uns(i_r1_uns),
        .i_r0_wdata(i_r0_wdata), .i_r1_wdata(i_r1_wdata),
        .o_r0_rsp_valid(o_r0_rsp_valid), .o_r1_rsp_valid(o_r1_rsp_valid),
        .o_r0_rsp_rdata(o_r0_rsp_rdata), .o_r1_rsp_rdata(o_r1_rsp_rdata),
        .o_r0_rsp_err(o_r0_rsp_err), .o_r1_rsp_err(o_r1_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  rmem [256];   // reference view, byte addressed
    logic [31:0] pmem [64];    // physical RAM behind the DUT

    // arbitration reference state
    int waits;                 // consecutive cycles r1 lost
    bit last1;                 // r1 won most recently

    // expected response for the previous cycle
    bit          p_vld, p_id, p_err;
    logic [31:0] p_rd;

    // observations kept for directed checks
    logic [31:0] last_rd0, last_rd1, last_wdata;
    logic        last_err1, last_wren;
    logic [3:0]  last_bmask;
    logic [7:0]  r1_log;

    req_t idle = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [15:0] a, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] wd);
        req_t q;
        q.addr = a; q.we = we; q.size = sz; q.uns = uns; q.wdata = wd;
        return q;
    endfunction

    function automatic req_t rnd_req();
        req_t q;
        q.size  = ($urandom % 16 == 0) ? 2'b11 : 2'($urandom % 3);
        q.addr  = 16'($urandom % 256);
        if ($urandom % 4 != 0) begin
            if (q.size == 2'b01) q.addr[0] = 1'b0;
            if (q.size == 2'b10) q.addr[1:0] = 2'b00;
        end
        q.we    = 1'($urandom % 2);
        q.uns   = 1'($urandom % 2);
        q.wdata = $urandom;
        return q;
    endfunction

    // Spec-level effect of one accepted request on the reference memory.
    task automatic model(input req_t q, output logic e, output logic [3:0] m,
                         output logic [31:0] wd, output logic [31:0] rd);
        int n, off, a;
        logic [31:0] v;
        off = int'(q.addr[1:0]);
        a   = int'(q.addr[7:0]);
        case (q.size)
            2'b00:   begin n = 1; e = 1'b0; end
            2'b01:   begin n = 2; e = (off % 2) != 0; end
            2'b10:   begin n = 4; e = (off != 0); end
            default: begin n = 4; e = 1'b1; end
        endcase
        m = '0; wd = '0; rd = '0; v = '0;
        for (int k = 0; k < 4; k++) begin
            m[k] = !e && (k >= off) && (k < off + n);
            wd[8*k +: 8] = q.wdata[8*(k % n) +: 8];
        end
        if (!e) begin
            if (q.we) begin
                for (int i = 0; i < n; i++) rmem[a+i] = q.wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[a+i];
                if (!q.uns && n < 4 && v[8*n-1])
                    for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
                rd = v;
            end
        end
    endtask

    // One clock cycle: check last cycle's response, drive, check grant and
    // memory port, then advance the RAM at the rising edge.
    task automatic cycle(input bit v0, input req_t q0, input bit v1, input req_t q1);
        bit g0, g1;
        req_t q;
        logic e, mw;
        logic [3:0] m, mm;
        logic [31:0] wd, rd, md, old;
        logic [5:0] mi;

        @(negedge i_clk);
        chk("r0_rsp_valid", 32'(o_r0_rsp_valid), 32'(p_vld && !p_id));
        chk("r1_rsp_valid", 32'(o_r1_rsp_valid), 32'(p_vld && p_id));
        if (p_vld && !p_id) begin
            chk("r0_rsp_rdata", o_r0_rsp_rdata, p_rd);
            chk("r0_rsp_err", 32'(o_r0_rsp_err), 32'(p_err));
            last_rd0 = o_r0_rsp_rdata;
        end
        if (p_vld && p_id) begin
            chk("r1_rsp_rdata", o_r1_rsp_rdata, p_rd);
            chk("r1_rsp_err", 32'(o_r1_rsp_err), 32'(p_err));
            last_rd1  = o_r1_rsp_rdata;
            last_err1 = o_r1_rsp_err;
        end

        i_r0_valid = v0; i_r0_addr = q0.addr; i_r0_we = q0.we; i_r0_size = q0.size;
        i_r0_uns = q0.uns; i_r0_wdata = q0.wdata;
        i_r1_valid = v1; i_r1_addr = q1.addr; i_r1_we = q1.we; i_r1_size = q1.size;
        i_r1_uns = q1.uns; i_r1_wdata = q1.wdata;
        #1;

`ifdef DMEM_ARB_RR_EN
        g1 = v1 && (!v0 || !last1);
`else
        g1 = v1 && (!v0 || waits == SMAX);
`endif
        g0 = v0 && !g1;
        chk("r0_ready", 32'(o_r0_ready), 32'(g0));
        chk("r1_ready", 32'(o_r1_ready), 32'(g1));
        r1_log = {o_r1_ready, r1_log[7:1]};

        p_vld = g0 || g1;
        p_id  = g1;
        if (p_vld) begin
            q = g1 ? q1 : q0;
            model(q, e, m, wd, rd);
            p_err = e;
            p_rd  = rd;
            chk("mem_addr", 32'(o_mem_addr), 32'({q.addr[15:2], 2'b00}));
            chk("mem_bmask", 32'(o_mem_bmask), 32'(m));
            chk("mem_wren", 32'(o_mem_wren), 32'(q.we && !e));
            if (q.we && !e) chk("mem_wdata", o_mem_wdata, wd);
        end else begin
            p_err = 1'b0;
            p_rd  = '0;
            chk("idle_addr", 32'(o_mem_addr), 32'h0);
            chk("idle_bmask", 32'(o_mem_bmask), 32'h0);
            chk("idle_wren", 32'(o_mem_wren), 32'h0);
        end
        last_bmask = o_mem_bmask;
        last_wdata = o_mem_wdata;
        last_wren  = o_mem_wren;

        if (g0 && v1) waits = (waits < SMAX) ? waits + 1 : SMAX;
        else          waits = 0;
        if (g0 || g1) last1 = g1;

        mw = o_mem_wren; mm = o_mem_bmask; md = o_mem_wdata; mi = o_mem_addr[7:2];
        @(posedge i_clk);
        old = pmem[mi];
        if (mw)
            for (int k = 0; k < 4; k++)
                if (mm[k]) pmem[mi][8*k +: 8] = md[8*k +: 8];
        i_mem_rdata = old;
    endtask

    // Assert reset at a falling edge (optionally with r0 still requesting),
    // check outputs are quiet, hold, release and clear the reference state.
    task automatic reset_pulse(input bit keep_v0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_r0_valid = keep_v0;
        i_r1_valid = keep_v0;
        #1;
        chk("rst_r0_ready", 32'(o_r0_ready), 32'h0);
        chk("rst_r1_ready", 32'(o_r1_ready), 32'h0);
        chk("rst_r0_rsp_valid", 32'(o_r0_rsp_valid), 32'h0);
        chk("rst_r1_rsp_valid", 32'(o_r1_rsp_valid), 32'h0);
        chk("rst_r0_rdata", o_r0_rsp_rdata, 32'h0);
        chk("rst_r0_err", 32'(o_r0_rsp_err), 32'h0);
        chk("rst_wren", 32'(o_mem_wren), 32'h0);
        chk("rst_bmask", 32'(o_mem_bmask), 32'h0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_r0_valid = 1'b0;
        i_r1_valid = 1'b0;
        i_rst_n = 1'b1;
        p_vld = 0; p_err = 0; p_rd = '0; waits = 0; last1 = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++)
            pmem[i] = {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
        p_vld = 0; p_id = 0; p_err = 0; p_rd = '0; waits = 0; last1 = 1;
        r1_log = '0;

        reset_pulse(1'b0);
        repeat (2) cycle(0, idle, 0, idle);

        // byte store of 0x80 at 3, then signed and unsigned byte loads
        cycle(1, mk(16'h0003, 1, 2'b00, 0, 32'h80), 0, idle);
        chk("sb_bmask", 32'(last_bmask), 32'h8);
        chk("sb_wdata", last_wdata, 32'h80808080);
        cycle(1, mk(16'h0003, 0, 2'b00, 0, 0), 0, idle);
        cycle(1, mk(16'h0003, 0, 2'b00, 1, 0), 0, idle);
        chk("lb_signed", last_rd0, 32'hFFFFFF80);
        cycle(0, idle, 0, idle);
        chk("lb_unsigned", last_rd0, 32'h00000080);

        // half loads from r1, aligned and misaligned
        cycle(1, mk(16'h0010, 1, 2'b10, 0, 32'hA1B2C3D4), 0, idle);
        cycle(0, idle, 1, mk(16'h0012, 0, 2'b01, 0, 0));
        cycle(0, idle, 1, mk(16'h0011, 0, 2'b01, 0, 0));
        chk("lh_signed", last_rd1, 32'hFFFFA1B2);
        chk("lh_mis_wren", 32'(last_wren), 32'h0);
        chk("lh_mis_bmask", 32'(last_bmask), 32'h0);
        cycle(0, idle, 0, idle);
        chk("lh_mis_err", 32'(last_err1), 32'h1);
        chk("lh_mis_rdata", last_rd1, 32'h0);

        // load followed immediately by a store to the same word
        cycle(1, mk(16'h0020, 1, 2'b10, 0, 32'h12345678), 0, idle);
        cycle(1, mk(16'h0020, 0, 2'b10, 0, 0), 0, idle);
        cycle(0, idle, 1, mk(16'h0020, 1, 2'b10, 0, 32'hDEADBEEF));
        chk("ld_before_st", last_rd0, 32'h12345678);
        cycle(1, mk(16'h0020, 0, 2'b10, 0, 0), 0, idle);
        cycle(0, idle, 0, idle);
        chk("ld_after_st", last_rd0, 32'hDEADBEEF);

        // continuous contention from a clean arbiter state
        reset_pulse(1'b0);
        r1_log = '0;
        for (int i = 0; i < 8; i++)
            cycle(1, mk(16'h0004, 0, 2'b10, 0, 0), 1, mk(16'h0008, 0, 2'b10, 0, 0));
`ifdef DMEM_ARB_RR_EN
        chk("contend_seq", 32'(r1_log), 32'hAA);
`else
        chk("contend_seq", 32'(r1_log), 32'h88);
`endif
        cycle(0, idle, 0, idle);

        // reset in the cycle the load response is due
        cycle(1, mk(16'h0008, 0, 2'b10, 0, 0), 0, idle);
        reset_pulse(1'b1);
        repeat (3) cycle(0, idle, 0, idle);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom % 10 < 7), rnd_req(), 1'($urandom % 10 < 6), rnd_req());
        cycle(0, idle, 0, idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
